// File: rtl/argmax_theta_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_theta_pkg
//  Description : Shared types and sizing for the argmax_theta peak search.
//                Optional feature macro: ARGMAX_THRESH_EN (see argmax_theta).
//  Revision    : 1.0 - initial release
// ============================================================================
package argmax_theta_pkg;

  // Samples per search window (power of two) and metric width.
  parameter int unsigned N_WIN    = 256;
  parameter int unsigned METRIC_W = 24;

  // Index width; kept at least one bit so a degenerate window still elaborates.
  localparam int unsigned THETA_W = (N_WIN > 1) ? $clog2(N_WIN) : 1;

  typedef logic [THETA_W-1:0]  theta_t;
  typedef logic [METRIC_W-1:0] metric_t;

  // Index of the newest sample of a window.
  localparam theta_t C_LAST_IDX = theta_t'(N_WIN - 1);

endpackage : argmax_theta_pkg
`default_nettype wire

// File: rtl/argmax_theta_if.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_theta_if
//  Description : Sample stream in / window result out for argmax_theta.
//                master = producer of metrics and consumer of results,
//                slave  = the argmax_theta block itself.
//                With ARGMAX_THRESH_EN defined a thresh_in signal is added.
//  Revision    : 1.0 - initial release
// ============================================================================
interface argmax_theta_if;
  import argmax_theta_pkg::*;

  logic    sync_clear;
  metric_t metric_in;
  logic    metric_valid;
`ifdef ARGMAX_THRESH_EN
  metric_t thresh_in;
`endif
  theta_t  theta_out;
  metric_t max_out;
  logic    argmax_valid;

  modport master (
    output sync_clear,
    output metric_in,
    output metric_valid,
`ifdef ARGMAX_THRESH_EN
    output thresh_in,
`endif
    input  theta_out,
    input  max_out,
    input  argmax_valid
  );

  modport slave (
    input  sync_clear,
    input  metric_in,
    input  metric_valid,
`ifdef ARGMAX_THRESH_EN
    input  thresh_in,
`endif
    output theta_out,
    output max_out,
    output argmax_valid
  );

endinterface : argmax_theta_if
`default_nettype wire

// File: rtl/argmax_theta.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_theta
//  Description : Streaming peak search. Tracks the running maximum of the
//                timing metric over windows of N_WIN accepted samples and, one
//                cycle after the last sample of a window, presents the
//                in-window index of the maximum (0 = oldest) with a one-cycle
//                argmax_valid pulse. Ties keep the earliest index.
//                Optional macro ARGMAX_THRESH_EN: adds thresh_in; the pulse is
//                only issued when the window maximum is >= thresh_in.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmax_theta
  import argmax_theta_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst_n,
  argmax_theta_if.slave      bus
);

  // State encoding
  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_EMIT   = 1'b1;

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;

  theta_t  r_count;     // in-window index of the next accepted sample
  metric_t r_run_max;   // running maximum of the current window
  theta_t  r_run_idx;   // index of the running maximum
  theta_t  r_theta;     // result of the last completed window
  metric_t r_max;

  theta_t  w_idx;       // index the sample on the bus would take
  logic    w_first;
  logic    w_take;
  logic    w_last;
  metric_t w_cand_max;  // running max including the current sample
  theta_t  w_cand_idx;

  // Resolve the current sample's index and whether it becomes the new maximum.
  // A restart makes the incoming sample index 0 of a fresh window, so the
  // first-sample load also discards any stale maximum.
  always_comb begin
    w_idx      = bus.sync_clear ? '0 : r_count;
    w_first    = (w_idx == '0);
    w_take     = bus.metric_valid && (w_first || (bus.metric_in > r_run_max));
    w_cand_max = w_take ? bus.metric_in : r_run_max;
    w_cand_idx = w_take ? w_idx : r_run_idx;
    w_last     = bus.metric_valid && (w_idx == C_LAST_IDX);
  end

  // Sample counter: advances per accepted sample, wraps at the window size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (bus.metric_valid) begin
      r_count <= theta_t'(w_idx + 1'b1);
    end else if (bus.sync_clear) begin
      r_count <= '0;
    end
  end

  // Running maximum and its index for the window in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_max <= '0;
      r_run_idx <= '0;
    end else if (bus.metric_valid) begin
      r_run_max <= w_cand_max;
      r_run_idx <= w_cand_idx;
    end else if (bus.sync_clear) begin
      r_run_max <= '0;
      r_run_idx <= '0;
    end
  end

  // Result registers: capture the final comparison of a completed window and
  // hold it until the next window completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_theta <= '0;
      r_max   <= '0;
    end else if (w_last) begin
      r_theta <= w_cand_idx;
      r_max   <= w_cand_max;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: EMIT lasts exactly one cycle; a sample arriving in EMIT
  // already belongs to the next window, so no dead cycle is needed.
  always_comb begin
    w_state_nxt = S_SEARCH;
    case (r_state)
      S_SEARCH: w_state_nxt = w_last ? S_EMIT : S_SEARCH;
      S_EMIT:   w_state_nxt = w_last ? S_EMIT : S_SEARCH;
      default:  w_state_nxt = S_SEARCH;
    endcase
  end

  // FSM outputs: the pulse comes straight from the registered state, so a
  // restart in the EMIT cycle cannot retract a pulse already on the bus.
  always_comb begin
    bus.theta_out    = r_theta;
    bus.max_out      = r_max;
`ifdef ARGMAX_THRESH_EN
    bus.argmax_valid = (r_state == S_EMIT) && (r_max >= bus.thresh_in);
`else
    bus.argmax_valid = (r_state == S_EMIT);
`endif
  end

endmodule : argmax_theta
`default_nettype wire

// File: tb/tb_argmax_theta.sv
`default_nettype none
// ============================================================================
//  Module      : tb_argmax_theta
//  Description : Scoreboard bench for argmax_theta. A window-level reference
//                model predicts each result and the cycle it should appear;
//                a monitor compares every cycle against the scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_theta;
  import argmax_theta_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  argmax_theta_if bus();

  argmax_theta dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    theta_t  theta;
    metric_t mx;
    int      cyc;
    bit      pulse;
  } exp_t;

  exp_t    sb[$];
  metric_t mwin[$];
  metric_t win[N_WIN];
  int      cyc = 0;
  int      n_vec = 0;
  int      n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: collect accepted samples; a full window yields the
  // earliest index of its maximum, due on the cycle after the last sample.
  function automatic void model_step(input bit v, input metric_t m, input bit clr);
    exp_t    e;
    metric_t best;
    int      bi;
    if (clr) mwin.delete();
    if (v) begin
      mwin.push_back(m);
      if (mwin.size() == N_WIN) begin
        best = mwin[0];
        bi   = 0;
        for (int i = 1; i < N_WIN; i++)
          if (mwin[i] > best) begin best = mwin[i]; bi = i; end
        e.theta = theta_t'(bi);
        e.mx    = best;
        e.cyc   = cyc + 1;
`ifdef ARGMAX_THRESH_EN
        e.pulse = (best >= bus.thresh_in);
`else
        e.pulse = 1'b1;
`endif
        sb.push_back(e);
        mwin.delete();
      end
    end
  endfunction

  task automatic drive(input bit v, input metric_t m, input bit clr);
    @(negedge clk);
    bus.metric_valid = v;
    bus.metric_in    = v ? m : metric_t'($urandom);
    bus.sync_clear   = clr;
    model_step(v, m, clr);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  // Send the contents of win[] as one window, with random idle gaps.
  task automatic run_window(input int gap_pct, input bit clr_first);
    for (int i = 0; i < N_WIN; i++) begin
      while (int'($urandom_range(99)) < gap_pct) idle();
      drive(1'b1, win[i], clr_first && (i == 0));
    end
  endtask

  // Monitor: compare on the predicted cycle, otherwise demand no pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("argmax_valid", 32'(bus.argmax_valid), 32'(e.pulse));
        check("theta_out", 32'(bus.theta_out), 32'(e.theta));
        check("max_out", 32'(bus.max_out), 32'(e.mx));
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("missed_result", 32'(e.cyc), 32'(cyc));
      end else begin
        check("spurious_pulse", 32'(bus.argmax_valid), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.metric_valid = 1'b0;
    bus.metric_in    = '0;
    bus.sync_clear   = 1'b0;
`ifdef ARGMAX_THRESH_EN
    bus.thresh_in    = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset_theta", 32'(bus.theta_out), 32'd0);
    check("reset_max", 32'(bus.max_out), 32'd0);
    check("reset_valid", 32'(bus.argmax_valid), 32'd0);
    rst_n = 1'b1;
    idle();

    // Ramp, continuous.
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'(i);
    run_window(0, 1'b0);

    // Single peak, twice back to back (no carry-over).
    for (int i = 0; i < N_WIN; i++) win[i] = 5;
    win[37] = 1000;
    run_window(0, 1'b0);
    run_window(0, 1'b0);

    // Tie keeps earliest index.
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom_range(899));
    win[10]  = 900;
    win[200] = 900;
    run_window(0, 1'b0);

    // 50% valid gaps, peak at 128.
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom_range(99999));
    win[128] = 200000;
    run_window(50, 1'b0);
    repeat (3) idle();

    // Aborted window with large early peak, then a clean window.
    for (int i = 0; i < 100; i++) drive(1'b1, (i == 50) ? metric_t'(5000) : metric_t'($urandom_range(299)), 1'b0);
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom_range(299));
    win[20] = 300;
    run_window(0, 1'b0);

    // Restart with a valid sample in the same cycle; the sample is index 0.
    for (int i = 0; i < 30; i++) drive(1'b1, 24'hFFFFFF, 1'b0);
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom_range(776));
    win[0] = 777;
    run_window(0, 1'b1);
    // Restart landing in the EMIT cycle: pulse still issued.
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom);
    run_window(0, 1'b1);

    // All-zero window.
    for (int i = 0; i < N_WIN; i++) win[i] = '0;
    run_window(10, 1'b0);

    // Full-range random windows with light gaps.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom);
      run_window(20, 1'b0);
    end
    repeat (3) idle();

`ifdef ARGMAX_THRESH_EN
    bus.thresh_in = 500;
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom_range(399));
    win[77] = 400;
    run_window(0, 1'b0);
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom_range(599));
    win[3] = 600;
    run_window(0, 1'b0);
    repeat (3) idle();
    bus.thresh_in = '0;
    idle();
`endif

    // Reset mid-window: outputs clear at once, partial window yields nothing.
    for (int i = 0; i < 100; i++) drive(1'b1, metric_t'($urandom), 1'b0);
    @(negedge clk);
    bus.metric_valid = 1'b0;
    rst_n = 1'b0;
    mwin.delete();
    #1;
    check("midreset_theta", 32'(bus.theta_out), 32'd0);
    check("midreset_max", 32'(bus.max_out), 32'd0);
    check("midreset_valid", 32'(bus.argmax_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N_WIN; i++) win[i] = metric_t'($urandom_range(1000));
    win[255] = 1001;
    run_window(0, 1'b0);

    repeat (5) idle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_argmax_theta
`default_nettype wire
